// File: rtl/restoring_divider4.sv
// Multi-cycle unsigned restoring divider: one quotient bit per RUN cycle, MSB first.
// Define RESTORING_DIVIDER_BACK2BACK_EN to let DONE accept a new start with no idle gap.
module restoring_divider4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             accept;

  // dvd_q doubles as the quotient shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_q};
    q_bit   = ~diff[WIDTH+1];
    rem_d   = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_d   = {dvd_q[WIDTH-2:0], q_bit};
  end

`ifdef RESTORING_DIVIDER_BACK2BACK_EN
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
`else
  assign accept = start && (state_q == IDLE);
`endif

  assign dbg_state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        RUN: begin
          dvd_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q     <= DONE;
            done        <= 1'b1;
            quotient    <= quo_d;
            remainder   <= rem_d;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: ;
      endcase
      // Acceptance overrides the DONE->IDLE return when back-to-back is enabled.
      if (accept) begin
        dvd_q <= dividend;
        dvs_q <= divisor;
        rem_q <= '0;
        cnt_q <= CW'(WIDTH - 1);
        busy  <= 1'b1;
        if (divisor == '0) begin
          state_q     <= DONE;
          done        <= 1'b1;
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          state_q <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider4.sv
// Directed-vector bench for restoring_divider4 with hand-computed results.
module tb_restoring_divider4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic [1:0] dbg_state_o;

  int checks = 0;
  int errors = 0;

  restoring_divider4 #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state_o (dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0 || dbg_state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b q=%0d r=%0d dbz=%b st=%0d, want all 0",
               busy, done, quotient, remainder, div_by_zero, dbg_state_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Issues one single-cycle start and checks latency, busy length and results.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                        input logic [3:0] er, input logic edbz, input int elat, input string name);
    int lat;
    int bcnt;
    lat = 0; bcnt = 0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      dividend = ~a; divisor = ~b;
      if (busy) bcnt++;
      if (done) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat !== elat) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, elat);
    end
    checks++;
    if (quotient !== eq || remainder !== er || div_by_zero !== edbz) begin
      errors++;
      $display("FAIL %s_result: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
               name, quotient, remainder, div_by_zero, eq, er, edbz);
    end
    checks++;
    if (bcnt !== elat) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", name, bcnt, elat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq || remainder !== er) begin
      errors++;
      $display("FAIL %s_after: done=%b busy=%b q=%0d r=%0d want done=0 busy=0 q=%0d r=%0d",
               name, done, busy, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_basic();
    do_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, "div_13_3");
    do_div(4'd3, 4'd9, 4'd0, 4'd3, 1'b0, 5, "div_3_9");
    do_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, "div_15_1");
    do_div(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 5, "div_14_4");
    do_div(4'd10, 4'd7, 4'd1, 4'd3, 1'b0, 5, "div_10_7");
    do_div(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 5, "div_0_5");
    do_div(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5, "div_15_15");
  endtask

  task automatic test_div_by_zero();
    do_div(4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 1, "div_7_0");
    do_div(4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 5, "div_8_2");
  endtask

  task automatic test_ignore_start();
    int ndone;
    int first;
    ndone = 0; first = 0;
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      dividend = 4'd15; divisor = 4'd5;
      start = (c == 2);
      if (done) begin
        ndone++;
        if (first == 0) first = c;
        checks++;
        if (quotient !== 4'd4 || remainder !== 4'd1) begin
          errors++;
          $display("FAIL ignore_start_result: got q=%0d r=%0d want q=4 r=1", quotient, remainder);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1 || first !== 5) begin
      errors++;
      $display("FAIL ignore_start_dones: got %0d pulses first at %0d want 1 at 5", ndone, first);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    ndone = 0;
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0 || dbg_state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b q=%0d r=%0d dbz=%b st=%0d, want all 0",
               busy, done, quotient, remainder, div_by_zero, dbg_state_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done pulses want 0", ndone);
    end
    do_div(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 5, "div_9_2");
  endtask

  task automatic test_back_to_back();
    int ndone;
    int t[2];
    logic [3:0] q[2];
    logic [3:0] r[2];
    int egap;
`ifdef RESTORING_DIVIDER_BACK2BACK_EN
    egap = 5;
`else
    egap = 6;
`endif
    ndone = 0; t[0] = 0; t[1] = 0;
    q[0] = 4'd0; q[1] = 4'd0; r[0] = 4'd0; r[1] = 4'd0;
    @(negedge clk);
    dividend = 4'd12; divisor = 4'd4; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      dividend = 4'd10; divisor = 4'd3;
      if (c == 7) start = 1'b0;
      if (done) begin
        if (ndone < 2) begin
          t[ndone] = c; q[ndone] = quotient; r[ndone] = remainder;
        end
        ndone++;
      end
    end
    checks++;
    if (ndone !== 2 || t[0] !== 5 || (t[1] - t[0]) !== egap) begin
      errors++;
      $display("FAIL b2b_timing: got %0d pulses at %0d,%0d want 2 at 5 and %0d",
               ndone, t[0], t[1], 5 + egap);
    end
    checks++;
    if (q[0] !== 4'd3 || r[0] !== 4'd0 || q[1] !== 4'd3 || r[1] !== 4'd1) begin
      errors++;
      $display("FAIL b2b_results: got %0d r%0d, %0d r%0d want 3 r0, 3 r1", q[0], r[0], q[1], r[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_by_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
